instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Boot-time loader that is the write side of the instruction memory: it accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit MIPS instruction words, and writes them sequentially into the instruction memory through a write port. While loading it holds the single-cycle CPU in reset, and it releases the CPU once the full program has been written. It sits between the board-level byte source (UART receiver or testbench) and the write port of `Instr_Memory`.

## Interface
Parameters:
- `ADDR_W`, 10: instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `start_i` in 1: one-cycle request to begin a load. Honoured only in IDLE, DONE or ERR.
- `byte_i` in 8: stream byte.
- `byte_valid_i` in 1: `byte_i` is valid.
- `byte_ready_o` out 1: loader accepts a byte. A transfer occurs when valid and ready are both high on the clock edge.
- `imem_we_o` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr_o` out ADDR_W+2: byte address for the write. Bits [1:0] are always 0.
- `imem_data_o` out 32: instruction word to write.
- `cpu_rst_o` out 1: reset to the CPU, high while not DONE.
- `busy_o` out 1: a load is in progress.
- `done_o` out 1: load completed successfully. Sticky until the next `start_i`.
- `err_o` out 1: load aborted. Sticky until the next `start_i`.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes with each word big-endian (first byte is instr[31:24]), then an optional checksum byte (see Configuration).
- States:
  - IDLE → LEN_LO on `start_i`.
  - LEN_LO → LEN_HI on a transfer.
  - LEN_HI → DATA on a transfer.
  - DATA → CHK (checksum build) or DONE after the 4·N-th byte.
  - CHK → DONE or ERR.
  - DONE or ERR → LEN_LO on `start_i`.
- Length checks:
  - N = 0: LEN_HI goes directly to CHK or DONE, and no writes occur.
  - N > 2^ADDR_W: go to ERR on the LEN_HI transfer, and no writes occur.
- `byte_ready_o` is high in LEN_LO, LEN_HI, DATA and CHK, and low elsewhere. The loader never stalls the stream mid-load.
- Byte packing: a 2-bit byte counter shifts bytes into a 32-bit register. On the 4th byte, the word is registered to `imem_data_o`.
- Addressing: the word address starts at 0 on every `start_i` and increments by 1 after each write. `imem_addr_o` = {word_addr, 2'b00}. A word count up to exactly 2^ADDR_W is legal, and the final address is (2^ADDR_W − 1)·4.
- `start_i` while `busy_o` is high is ignored.
- `rst_i` mid-load: go to IDLE immediately. The partial word is discarded, no write is issued, and `cpu_rst_o` = 1.
- Reset values:
  - state IDLE
  - `cpu_rst_o` = 1
  - `byte_ready_o`, `imem_we_o`, `busy_o`, `done_o`, `err_o` = 0
  - `imem_addr_o`, `imem_data_o` = 0

## Timing
- Write latency: if the 4th byte of word k transfers at edge T, then `imem_we_o` = 1 with address 4k and the word data during the cycle after T. The strobe lasts exactly 1 cycle.
- Back-to-back bytes at 1 byte/cycle are supported, giving at most 1 write per 4 cycles.
- After the last write strobe (no checksum build), `done_o` rises and `cpu_rst_o` falls in the next cycle.
- `busy_o` = 1 from the cycle after `start_i` until the cycle DONE or ERR is entered.
- ERR entry: `err_o` = 1 and `cpu_rst_o` stays 1.
- `start_i` in DONE: `cpu_rst_o` returns to 1 in the next cycle, and `done_o` clears.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum (mod 256) of the payload bytes is kept.
  - After the payload, the loader enters CHK and accepts 1 byte.
  - If the byte equals the sum, go to DONE.
  - Otherwise go to ERR. Words already written stay in memory, and the CPU stays in reset.
- Not defined: the CHK state and the sum logic are absent, and DATA goes directly to DONE.

## Structure
- Package `loader_pkg`: state enum (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR), `WORD_BYTES` = 4, `LEN_W` = 16.
- Sub-module `word_packer`: byte counter, shift register, and word-ready pulse. The FSM, address counter and checksum stay in the top level.

## Test plan
- Reset, then N=2 with bytes 8C,01,00,04,AC,02,00,08 at 1/cycle:
  - writes 0x8C010004 at address 0 and 0xAC020008 at address 4, one cycle after each 4th byte.
  - `done_o`=1 and `cpu_rst_o`=0 in the cycle after the second write.
- N=0: no `imem_we_o`, and `done_o` is set with checksum off. With the macro on, checksum byte 00 gives `done_o`.
- N = 2^ADDR_W+1: `err_o`=1 after LEN_HI, no writes, `cpu_rst_o` stays 1.
- `LOADER_CHECKSUM_EN`, one word 00,00,00,01:
  - checksum 01 gives `done_o`.
  - checksum 02 gives `err_o`, with the write at address 0 still performed.
- Deassert `byte_valid_i` for 5 cycles between bytes 2 and 3: the packed word and address are unchanged, with a single write of the correct word.
- `rst_i` after 6 payload bytes: exactly 1 write occurred, the state is IDLE, and a following `start_i` restarts the load at address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the instruction-memory boot loader.
//   state_t       : loader FSM states
//   WORD_BYTES    : bytes per instruction word
//   LEN_W         : width of the word-count header field
//   accepts_start : true in the states where a new load may be requested
// ---------------------------------------------------------------------------
package loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  function automatic logic accepts_start(input state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/word_packer.sv
// ---------------------------------------------------------------------------
// word_packer
// Packs a byte stream into big-endian 32-bit words (first byte -> [31:24]).
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : discard any partial word (new load)
//   take_i         : consume byte_i this cycle
//   byte_i         : stream byte
//   last_byte_o    : combinational, high when the byte taken completes a word
//   word_valid_o   : registered one-cycle pulse, word_o holds a fresh word
//   word_o         : most recently completed word (held between pulses)
// ---------------------------------------------------------------------------
module word_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      word_q, word_d;
  logic             valid_q, valid_d;

  assign last_byte_o = take_i && (cnt_q == CNT_W'(WORD_BYTES - 1));

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (take_i) begin
      shift_d = {shift_q[23:0], byte_i};
      if (last_byte_o) begin
        word_d  = shift_d;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (rst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
// Boot loader driving the instruction-memory write port. Receives
// LEN_LO, LEN_HI (word count N), 4*N big-endian payload bytes and, when
// LOADER_CHECKSUM_EN is defined, one trailing mod-256 checksum byte.
// The CPU is held in reset until a load completes successfully.
// Optional feature macro: LOADER_CHECKSUM_EN (checksum byte and CHK state).
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   start_i              : begin a load (honoured in IDLE, DONE, ERR)
//   byte_i, byte_valid_i : byte stream input
//   byte_ready_o         : loader accepts a byte this cycle
//   imem_we_o            : one-cycle write strobe per word
//   imem_addr_o          : byte address of the write, [1:0] = 0
//   imem_data_o          : instruction word
//   cpu_rst_o            : CPU reset, high unless DONE
//   busy_o               : load in progress
//   done_o, err_o        : sticky completion / abort flags
// ---------------------------------------------------------------------------
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W+1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              xfer;
  logic              start_ok;
  logic              take;
  logic              last_byte;
  logic              word_valid;
  logic [31:0]       word;
  logic [LEN_W-1:0]  len_rx;
  logic              len_over;
  logic              payload_done;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              final_byte;
`endif

  assign xfer         = byte_valid_i && byte_ready_o;
  assign start_ok     = start_i && accepts_start(state_q);
  assign len_rx       = {byte_i, len_lo_q};
  assign len_over     = 32'(len_rx) > MAX_WORDS;
  assign payload_done = (words_q == len_q);
  // Bytes beyond the payload (while the final write drains) never reach
  // the packer, so they cannot create a stray word.
  assign take         = xfer && (state_q == DATA) && !payload_done;

`ifdef LOADER_CHECKSUM_EN
  assign final_byte   = last_byte && ((words_q + LEN_W'(1)) == len_q);
`endif

  word_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (start_ok),
    .take_i       (take),
    .byte_i       (byte_i),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (start_i) state_d = LEN_LO;
      LEN_LO:          if (xfer) state_d = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (len_over) begin
            state_d = ERR;
          end else if (len_rx == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
`ifdef LOADER_CHECKSUM_EN
        // The checksum byte may follow the last payload byte immediately.
        if (final_byte) state_d = CHK;
`else
        // Leave only once the last word's strobe is on the bus, so done_o
        // rises in the cycle after the final write.
        if (payload_done) state_d = DONE;
`endif
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) state_d = (byte_i == sum_q) ? DONE : ERR;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    byte_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    cpu_rst_o    = 1'b1;
    unique case (state_q)
      LEN_LO, LEN_HI, DATA, CHK: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      DONE: begin
        done_o    = 1'b1;
        cpu_rst_o = 1'b0;
      end
      ERR:     err_o = 1'b1;
      default: ;
    endcase
  end

  // ---- Header, word counter, address counter, checksum ----
  always_comb begin
    len_lo_d = len_lo_q;
    len_d    = len_q;
    words_d  = words_q;
    addr_d   = addr_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    if (start_ok) begin
      words_d = '0;
      addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else begin
      if (xfer && (state_q == LEN_LO)) len_lo_d = byte_i;
      if (xfer && (state_q == LEN_HI)) len_d    = len_rx;
      if (last_byte)                   words_d  = words_q + LEN_W'(1);
      // Advance after the strobe so the address on the bus matches the word.
      if (word_valid)                  addr_d   = addr_q + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
      if (take)                        sum_d    = sum_q + byte_i;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_lo_q <= '0;
      len_q    <= '0;
      words_q  <= '0;
      addr_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign imem_we_o   = word_valid;
  assign imem_addr_o = {addr_q, 2'b00};
  assign imem_data_o = word;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
// Scoreboard bench: each completed word driven into the loader pushes the
// expected {address, data, cycle} write; a negedge monitor pops and compares
// every imem_we_o strobe. Works with and without LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam int ADDR_W = 10;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W+1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic              cpu_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .cpu_rst_o    (cpu_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [ADDR_W+1:0] addr;
    logic [31:0]       data;
    int                due;
  } wr_t;

  wr_t               exp_q[$];
  wr_t               mon_e;
  logic [7:0]        pay[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                cyc     = 0;
  int                wr_count = 0;
  int                wr_base;
  logic [31:0]       cur_word;
  logic [31:0]       last_word = '0;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] word_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk_i) begin
    if (imem_we_o === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr",  64'(imem_addr_o), 64'(mon_e.addr));
        check("wr_data",  64'(imem_data_o), 64'(mon_e.data));
        check("wr_cycle", 64'(cyc),         64'(mon_e.due));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid_i = 1'b1;
    byte_i       = b;
    check("ready", byte_ready_o, 1);
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic start_load(input logic [15:0] n);
    word_idx = '0;
    sum      = '0;
    cur_word = '0;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    check("start_busy",    busy_o,    1);
    check("start_cpu_rst", cpu_rst_o, 1);
    check("start_done",    done_o,    0);
    check("start_err",     err_o,     0);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  // Drives pay[first +: cnt]; a completed word is due on the bus during
  // the cycle right after its 4th byte edge.
  task automatic send_payload(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      send_byte(pay[i]);
      cur_word = {cur_word[23:0], pay[i]};
      sum      = sum + pay[i];
      if ((i % 4) == 3) begin
        exp_q.push_back('{addr: {word_idx, 2'b00}, data: cur_word, due: cyc});
        last_word = cur_word;
        word_idx  = word_idx + 1'b1;
      end
    end
  endtask

  // Called right after the last payload byte edge (the final write cycle).
  task automatic finish_load(input string tag);
    check({tag, "_done_early"}, done_o, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum);
`else
    tick();
`endif
    check({tag, "_done"},    done_o,    1);
    check({tag, "_cpu_rst"}, cpu_rst_o, 0);
    check({tag, "_busy"},    busy_o,    0);
    check({tag, "_pending"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_i       = '0;
    byte_valid_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // Reset state.
    check("rst_cpu_rst", cpu_rst_o,    1);
    check("rst_ready",   byte_ready_o, 0);
    check("rst_we",      imem_we_o,    0);
    check("rst_busy",    busy_o,       0);
    check("rst_done",    done_o,       0);
    check("rst_err",     err_o,        0);
    check("rst_addr",    64'(imem_addr_o), 0);
    check("rst_data",    64'(imem_data_o), 0);

    // N=2 at one byte per cycle.
    pay = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
    start_load(16'd2);
    send_payload(0, 8);
    finish_load("n2");

    // N=0 (start from DONE also exercises the restart behaviour).
    start_load(16'd0);
`ifdef LOADER_CHECKSUM_EN
    check("n0_done_before_chk", done_o, 0);
    send_byte(8'h00);
`endif
    check("n0_done",    done_o,    1);
    check("n0_cpu_rst", cpu_rst_o, 0);

    // N = 2^ADDR_W + 1 -> error right after LEN_HI, no writes.
    wr_base = wr_count;
    start_load(16'((1 << ADDR_W) + 1));
    check("over_err",     err_o,        1);
    check("over_cpu_rst", cpu_rst_o,    1);
    check("over_busy",    busy_o,       0);
    check("over_ready",   byte_ready_o, 0);
    tick();
    check("over_no_write", 64'(wr_count - wr_base), 0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch on a single word.
    pay = '{8'h00, 8'h00, 8'h00, 8'h01};
    start_load(16'd1);
    send_payload(0, 4);
    send_byte(8'h01);
    check("chk_ok_done", done_o, 1);
    check("chk_ok_err",  err_o,  0);
    start_load(16'd1);
    send_payload(0, 4);
    send_byte(8'h02);
    check("chk_bad_err",     err_o,     1);
    check("chk_bad_done",    done_o,    0);
    check("chk_bad_cpu_rst", cpu_rst_o, 1);
    check("chk_bad_pending", 64'(exp_q.size()), 0);
`endif

    // Five-cycle valid gap between bytes 2 and 3, with an ignored start.
    pay = '{8'h12, 8'h34, 8'h56, 8'h78};
    start_load(16'd1);
    send_payload(0, 2);
    for (int i = 0; i < 5; i++) begin
      start_i = (i == 2);
      tick();
      start_i = 1'b0;
      check("stall_data", 64'(imem_data_o), 64'(last_word));
      check("stall_addr", 64'(imem_addr_o), 0);
      check("stall_busy", busy_o, 1);
    end
    send_payload(2, 2);
    finish_load("stall");

    // Reset after 6 payload bytes of a 3-word load, then restart.
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88};
    wr_base = wr_count;
    start_load(16'd3);
    send_payload(0, 6);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    last_word = '0;
    check("mid_rst_writes",  64'(wr_count - wr_base), 1);
    check("mid_rst_busy",    busy_o,       0);
    check("mid_rst_ready",   byte_ready_o, 0);
    check("mid_rst_cpu_rst", cpu_rst_o,    1);
    check("mid_rst_done",    done_o,       0);
    check("mid_rst_err",     err_o,        0);
    check("mid_rst_addr",    64'(imem_addr_o), 0);
    check("mid_rst_data",    64'(imem_data_o), 0);
    tick();
    check("mid_rst_no_write", 64'(wr_count - wr_base), 1);
    pay = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    start_load(16'd1);
    send_payload(0, 4);
    finish_load("restart");

    repeat (4) tick();
    check("final_pending", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
